// File: rtl/axilite_rrarbiter.sv
// Purpose : round-robin share of one AXI-lite master port among NS slave ports;
//           write and read paths arbitrate independently, one transaction each.
// Latency : 1 cycle arbitration in IDLE, then valid/ready/payload pass straight through.
// Backpressure: READY/VALID forwarded combinationally to/from the granted port only;
//           the grant is held until the response handshake completes.
// Ports   : ACLK/ARESET; S_AXI_* packed per-port slave channels (port i at [i*W +: W]);
//           M_AXI_* single master channels. B/R payloads are replicated to every port.
module axilite_rrarbiter #(
   parameter int NS = 2,
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic              ACLK,
   input  logic              ARESET,
   // slave write address / data / response
   input  logic [NS-1:0]     S_AXI_AWVALID,
   output logic [NS-1:0]     S_AXI_AWREADY,
   input  logic [NS*AW-1:0]  S_AXI_AWADDR,
   input  logic [NS*3-1:0]   S_AXI_AWPROT,
   input  logic [NS-1:0]     S_AXI_WVALID,
   output logic [NS-1:0]     S_AXI_WREADY,
   input  logic [NS*DW-1:0]  S_AXI_WDATA,
   input  logic [NS*DW/8-1:0] S_AXI_WSTRB,
   output logic [NS-1:0]     S_AXI_BVALID,
   input  logic [NS-1:0]     S_AXI_BREADY,
   output logic [NS*2-1:0]   S_AXI_BRESP,
   // slave read address / data
   input  logic [NS-1:0]     S_AXI_ARVALID,
   output logic [NS-1:0]     S_AXI_ARREADY,
   input  logic [NS*AW-1:0]  S_AXI_ARADDR,
   input  logic [NS*3-1:0]   S_AXI_ARPROT,
   output logic [NS-1:0]     S_AXI_RVALID,
   input  logic [NS-1:0]     S_AXI_RREADY,
   output logic [NS*DW-1:0]  S_AXI_RDATA,
   output logic [NS*2-1:0]   S_AXI_RRESP,
   // master port
   output logic              M_AXI_AWVALID,
   input  logic              M_AXI_AWREADY,
   output logic [AW-1:0]     M_AXI_AWADDR,
   output logic [2:0]        M_AXI_AWPROT,
   output logic              M_AXI_WVALID,
   input  logic              M_AXI_WREADY,
   output logic [DW-1:0]     M_AXI_WDATA,
   output logic [DW/8-1:0]   M_AXI_WSTRB,
   input  logic              M_AXI_BVALID,
   output logic              M_AXI_BREADY,
   input  logic [1:0]        M_AXI_BRESP,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   output logic [AW-1:0]     M_AXI_ARADDR,
   output logic [2:0]        M_AXI_ARPROT,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY,
   input  logic [DW-1:0]     M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP
);

   localparam int GW = (NS > 1) ? $clog2(NS) : 1;
   localparam int SW = DW / 8;

   typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

   wstate_t       wstate;
   rstate_t       rstate;
   logic [GW-1:0] wgrant, wptr, rgrant, rptr;
   logic          aw_done, w_done;
   logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;

   // Lowest requester at or above ptr; if none, wrap to the lowest requester overall.
   function automatic logic [GW-1:0] rr_pick(input logic [NS-1:0] req, input logic [GW-1:0] ptr);
      logic [GW-1:0] lo, hi;
      logic          hi_found;
      lo       = '0;
      hi       = '0;
      hi_found = 1'b0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo = GW'(i);
            if (GW'(i) >= ptr) begin
               hi       = GW'(i);
               hi_found = 1'b1;
            end
         end
      end
      return hi_found ? hi : lo;
   endfunction

   function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
      return (g == GW'(NS - 1)) ? '0 : g + GW'(1);
   endfunction

   assign S_AXI_BRESP = {NS{M_AXI_BRESP}};
   assign S_AXI_RDATA = {NS{M_AXI_RDATA}};
   assign S_AXI_RRESP = {NS{M_AXI_RRESP}};

   // Routing: payloads always follow the grant; handshake signals only in the
   // state that owns that channel, so strays on the master side are held off.
   always_comb begin
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      S_AXI_AWREADY = '0;
      S_AXI_WREADY  = '0;
      S_AXI_BVALID  = '0;
      S_AXI_ARREADY = '0;
      S_AXI_RVALID  = '0;
      M_AXI_AWADDR  = S_AXI_AWADDR[AW-1:0];
      M_AXI_AWPROT  = S_AXI_AWPROT[2:0];
      M_AXI_WDATA   = S_AXI_WDATA[DW-1:0];
      M_AXI_WSTRB   = S_AXI_WSTRB[SW-1:0];
      M_AXI_ARADDR  = S_AXI_ARADDR[AW-1:0];
      M_AXI_ARPROT  = S_AXI_ARPROT[2:0];
      for (int i = 0; i < NS; i++) begin
         if (wgrant == GW'(i)) begin
            M_AXI_AWADDR = S_AXI_AWADDR[i*AW +: AW];
            M_AXI_AWPROT = S_AXI_AWPROT[i*3 +: 3];
            M_AXI_WDATA  = S_AXI_WDATA[i*DW +: DW];
            M_AXI_WSTRB  = S_AXI_WSTRB[i*SW +: SW];
            if (wstate == W_ACTIVE) begin
               M_AXI_AWVALID    = S_AXI_AWVALID[i] & ~aw_done;
               S_AXI_AWREADY[i] = M_AXI_AWREADY & ~aw_done;
               M_AXI_WVALID     = S_AXI_WVALID[i] & ~w_done;
               S_AXI_WREADY[i]  = M_AXI_WREADY & ~w_done;
            end
            if (wstate == W_RESP) begin
               S_AXI_BVALID[i] = M_AXI_BVALID;
               M_AXI_BREADY    = S_AXI_BREADY[i];
            end
         end
         if (rgrant == GW'(i)) begin
            M_AXI_ARADDR = S_AXI_ARADDR[i*AW +: AW];
            M_AXI_ARPROT = S_AXI_ARPROT[i*3 +: 3];
            if (rstate == R_ADDR) begin
               M_AXI_ARVALID    = S_AXI_ARVALID[i];
               S_AXI_ARREADY[i] = M_AXI_ARREADY;
            end
            if (rstate == R_DATA) begin
               S_AXI_RVALID[i] = M_AXI_RVALID;
               M_AXI_RREADY    = S_AXI_RREADY[i];
            end
         end
      end
   end

   assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
   assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;
   assign b_hs  = M_AXI_BVALID & M_AXI_BREADY;
   assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
   assign r_hs  = M_AXI_RVALID & M_AXI_RREADY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wstate  <= W_IDLE;
         wgrant  <= '0;
         wptr    <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (wstate)
            W_IDLE: begin
               // Only AWVALID opens a write; a lone WVALID waits.
               if (|S_AXI_AWVALID) begin
                  wgrant <= rr_pick(S_AXI_AWVALID, wptr);
                  wstate <= W_ACTIVE;
               end
            end
            W_ACTIVE: begin
               // AW and W complete independently, in either order or together.
               if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                  wstate  <= W_RESP;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end else begin
                  if (aw_hs) aw_done <= 1'b1;
                  if (w_hs)  w_done  <= 1'b1;
               end
            end
            W_RESP: begin
               if (b_hs) begin
                  wstate <= W_IDLE;
                  wptr   <= rr_next(wgrant);
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rstate <= R_IDLE;
         rgrant <= '0;
         rptr   <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (|S_AXI_ARVALID) begin
                  rgrant <= rr_pick(S_AXI_ARVALID, rptr);
                  rstate <= R_ADDR;
               end
            end
            R_ADDR: if (ar_hs) rstate <= R_DATA;
            R_DATA: begin
               if (r_hs) begin
                  rstate <= R_IDLE;
                  rptr   <= rr_next(rgrant);
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axilite_rrarbiter.sv
module tb_axilite_rrarbiter;
   localparam int NS = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              ACLK, ARESET;
   logic [NS-1:0]     S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
   logic [NS-1:0]     S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic [NS-1:0]     S_AXI_RVALID, S_AXI_RREADY;
   logic [NS*AW-1:0]  S_AXI_AWADDR, S_AXI_ARADDR;
   logic [NS*3-1:0]   S_AXI_AWPROT, S_AXI_ARPROT;
   logic [NS*DW-1:0]  S_AXI_WDATA, S_AXI_RDATA;
   logic [NS*DW/8-1:0] S_AXI_WSTRB;
   logic [NS*2-1:0]   S_AXI_BRESP, S_AXI_RRESP;
   logic              M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic              M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic              M_AXI_RVALID, M_AXI_RREADY;
   logic [AW-1:0]     M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
   logic [DW-1:0]     M_AXI_WDATA, M_AXI_RDATA;
   logic [DW/8-1:0]   M_AXI_WSTRB;
   logic [1:0]        M_AXI_BRESP, M_AXI_RRESP;

   int n_cmp = 0;
   int n_err = 0;

   axilite_rrarbiter #(.NS(NS), .AW(AW), .DW(DW)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BRESP(S_AXI_BRESP),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of run, expected finish before 100us");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      S_AXI_AWVALID = '0; S_AXI_WVALID = '0; S_AXI_BREADY = '0;
      S_AXI_ARVALID = '0; S_AXI_RREADY = '0;
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
   endtask

   initial begin
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0;
      M_AXI_BRESP = 2'b00; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;

      // 1: reset with every valid/ready driven high
      ARESET = 1'b1;
      S_AXI_AWVALID = '1; S_AXI_WVALID = '1; S_AXI_BREADY = '1;
      S_AXI_ARVALID = '1; S_AXI_RREADY = '1;
      M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1;
      M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1;
      step(); step();
      chk("rst_s_handshakes", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}, 64'h0);
      chk("rst_m_handshakes", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 64'h0);
      clear_inputs();
      ARESET = 1'b0;
      step();

      // 2: single write from port 1
      S_AXI_AWADDR[63:32] = 32'h0000_1000;
      S_AXI_WDATA[63:32]  = 32'hDEAD_BEEF;
      S_AXI_WSTRB[7:4]    = 4'hF;
      S_AXI_AWVALID = 2'b10; S_AXI_WVALID = 2'b10;
      #1 chk("w1_idle_no_awvalid", M_AXI_AWVALID, 0);
      step();
      chk("w1_m_awvalid", M_AXI_AWVALID, 1);
      chk("w1_m_awaddr", M_AXI_AWADDR, 32'h0000_1000);
      chk("w1_m_wdata", M_AXI_WDATA, 32'hDEAD_BEEF);
      chk("w1_m_wstrb", M_AXI_WSTRB, 4'hF);
      chk("w1_s_awready_held", S_AXI_AWREADY, 2'b00);
      M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
      #1 chk("w1_s_awready", S_AXI_AWREADY, 2'b10);
      chk("w1_s_wready", S_AXI_WREADY, 2'b10);
      step();
      clear_inputs();
      M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00; S_AXI_BREADY = 2'b10;
      #1 chk("w1_s_bvalid", S_AXI_BVALID, 2'b10);
      chk("w1_s_bresp", S_AXI_BRESP, 4'b0000);
      chk("w1_m_bready", M_AXI_BREADY, 1);
      step();
      clear_inputs();
      #1 chk("w1_b_done", S_AXI_BVALID, 2'b00);

      // 3: two simultaneous writers, rotation and wrap
      S_AXI_AWADDR = {32'h0000_0200, 32'h0000_0100};
      S_AXI_AWVALID = 2'b11; S_AXI_WVALID = 2'b11;
      M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; S_AXI_BREADY = 2'b11;
      #1 chk("rr_stray_bvalid_held", M_AXI_BREADY, 0);
      step();
      chk("rr_first_addr", M_AXI_AWADDR, 32'h0000_0100);
      chk("rr_first_awready", S_AXI_AWREADY, 2'b01);
      step();
      S_AXI_AWVALID = 2'b10; S_AXI_WVALID = 2'b10;
      #1 chk("rr_first_bvalid", S_AXI_BVALID, 2'b01);
      step();
      chk("rr_between_awvalid", M_AXI_AWVALID, 0);
      step();
      chk("rr_second_addr", M_AXI_AWADDR, 32'h0000_0200);
      chk("rr_second_awready", S_AXI_AWREADY, 2'b10);
      step();
      S_AXI_AWVALID = 2'b00; S_AXI_WVALID = 2'b00;
      #1 chk("rr_second_bvalid", S_AXI_BVALID, 2'b10);
      step();
      S_AXI_AWVALID = 2'b11; S_AXI_WVALID = 2'b11;
      step();
      chk("rr_wrap_addr", M_AXI_AWADDR, 32'h0000_0100);
      chk("rr_wrap_awready", S_AXI_AWREADY, 2'b01);
      step();
      S_AXI_AWVALID = 2'b00; S_AXI_WVALID = 2'b00;
      step();
      clear_inputs();

      // 4: W accepted while AW stalls; response only after AW completes
      S_AXI_AWADDR[31:0] = 32'h0000_0300;
      S_AXI_AWVALID = 2'b01; S_AXI_WVALID = 2'b01; M_AXI_WREADY = 1'b1;
      step();
      chk("stall_wready", S_AXI_WREADY, 2'b01);
      step();
      M_AXI_BVALID = 1'b1;
      #1 chk("stall_w_done_wready", S_AXI_WREADY, 2'b00);
      chk("stall_w_done_wvalid", M_AXI_WVALID, 0);
      chk("stall_awvalid", M_AXI_AWVALID, 1);
      chk("stall_no_bvalid", S_AXI_BVALID, 2'b00);
      step();
      chk("stall_still_no_resp", {S_AXI_BVALID, M_AXI_BREADY, M_AXI_WVALID}, 0);
      M_AXI_AWREADY = 1'b1;
      #1 chk("stall_awready", S_AXI_AWREADY, 2'b01);
      step();
      S_AXI_AWVALID = 2'b00; S_AXI_WVALID = 2'b00;
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; S_AXI_BREADY = 2'b01;
      #1 chk("stall_bvalid", S_AXI_BVALID, 2'b01);
      chk("stall_bready", M_AXI_BREADY, 1);
      step();
      clear_inputs();
      #1 chk("stall_one_b", S_AXI_BVALID, 2'b00);

      // 5: concurrent write (port 0) and read (port 1)
      M_AXI_RVALID = 1'b1;
      #1 chk("stray_rvalid_held", {M_AXI_RREADY, S_AXI_RVALID}, 0);
      M_AXI_RVALID = 1'b0;
      S_AXI_ARADDR[63:32] = 32'h0000_2000;
      S_AXI_WDATA[31:0]   = 32'hCAFE_0000;
      S_AXI_AWVALID = 2'b01; S_AXI_WVALID = 2'b01; S_AXI_ARVALID = 2'b10;
      step();
      chk("rd_arvalid", M_AXI_ARVALID, 1);
      chk("rd_araddr", M_AXI_ARADDR, 32'h0000_2000);
      chk("rd_wr_awvalid", M_AXI_AWVALID, 1);
      M_AXI_ARREADY = 1'b1;
      #1 chk("rd_arready", S_AXI_ARREADY, 2'b10);
      step();
      S_AXI_ARVALID = 2'b00; M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h1234_5678; S_AXI_RREADY = 2'b10;
      #1 chk("rd_rvalid", S_AXI_RVALID, 2'b10);
      chk("rd_rdata", S_AXI_RDATA[63:32], 32'h1234_5678);
      chk("rd_rready", M_AXI_RREADY, 1);
      chk("rd_wr_wdata", M_AXI_WDATA, 32'hCAFE_0000);
      step();
      M_AXI_RVALID = 1'b0; S_AXI_RREADY = 2'b00;
      M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
      #1 chk("rd_done", S_AXI_RVALID, 2'b00);
      chk("rd_wr_awready", S_AXI_AWREADY, 2'b01);
      step();
      clear_inputs();
      M_AXI_BVALID = 1'b1; S_AXI_BREADY = 2'b01;
      #1 chk("rd_wr_bvalid", S_AXI_BVALID, 2'b01);
      step();
      clear_inputs();

      // 6: reset while a response is pending
      S_AXI_AWVALID = 2'b01; S_AXI_WVALID = 2'b01; M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
      step();
      step();
      clear_inputs();
      M_AXI_BVALID = 1'b1;
      #1 chk("rst_mid_bvalid_before", S_AXI_BVALID, 2'b01);
      ARESET = 1'b1;
      #1 chk("rst_mid_bvalid_async", S_AXI_BVALID, 2'b00);
      step();
      ARESET = 1'b0;
      #1 chk("rst_mid_idle", {S_AXI_BVALID, M_AXI_BREADY}, 0);
      S_AXI_AWADDR = {32'h0000_1000, 32'h0000_0400};
      S_AXI_AWVALID = 2'b11; S_AXI_WVALID = 2'b11;
      M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
      M_AXI_BRESP = 2'b10; S_AXI_BREADY = 2'b11;
      step();
      chk("rst_mid_wptr0", S_AXI_AWREADY, 2'b01);
      step();
      S_AXI_AWVALID = 2'b10; S_AXI_WVALID = 2'b10;
      #1 chk("rst_mid_p0_bvalid", S_AXI_BVALID, 2'b01);
      chk("rst_mid_bresp", S_AXI_BRESP, 4'b1010);
      step();
      step();
      chk("rst_mid_p1_addr", M_AXI_AWADDR, 32'h0000_1000);
      chk("rst_mid_p1_wdata", M_AXI_WDATA, 32'hDEAD_BEEF);
      step();
      S_AXI_AWVALID = 2'b00; S_AXI_WVALID = 2'b00;
      #1 chk("rst_mid_p1_bvalid", S_AXI_BVALID, 2'b10);
      step();
      chk("rst_mid_p1_done", S_AXI_BVALID, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
